// File: rtl/obi_pkg.sv
// Shared types and constants for the OBI requester arbiter and its ID FIFO.
package obi_pkg;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

   localparam logic [5:0] OBI_ATOP_NONE = 6'b0;

   // Width of a requester index; never zero so single-bit ports stay legal.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/obi_id_fifo.sv
// In-order FIFO of requester indices, one entry per accepted-but-unanswered transaction.
module obi_id_fifo
   import obi_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int W     = 1,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [W-1:0]  push_id,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output logic [W-1:0]  head,
   output logic [CW-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) return '0;
      return p + PW'(1);
   endfunction

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

   always_comb begin
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_id;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/obi_arbiter.sv
// Round-robin arbiter sharing one OBI manager port between NUM_REQ requesters,
// with in-order response routing through an ID FIFO.
module obi_arbiter
   import obi_pkg::*;
#(
   parameter int WIDTH           = 32,
   parameter int NUM_REQ         = 2,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req_i,
   output logic [NUM_REQ-1:0]              gnt_o,
   input  logic [NUM_REQ-1:0][WIDTH-1:0]   addr_i,
   input  logic [NUM_REQ-1:0]              we_i,
   input  logic [NUM_REQ-1:0][3:0]         be_i,
   input  logic [NUM_REQ-1:0][WIDTH-1:0]   wdata_i,
   output logic [NUM_REQ-1:0]              rvalid_o,
   output logic [WIDTH-1:0]                rdata_o,
   output logic                            err_o,
   output logic                            obi_req_o,
   input  logic                            obi_gnt_i,
   output logic [WIDTH-1:0]                obi_addr_o,
   output logic                            obi_we_o,
   output logic [3:0]                      obi_be_o,
   output logic [WIDTH-1:0]                obi_wdata_o,
   output logic [5:0]                      obi_atop_o,
   input  logic [WIDTH-1:0]                obi_rdata_i,
   input  logic                            obi_rvalid_i,
   input  logic                            obi_err_i
);

   localparam int IDW = id_width(NUM_REQ);
   localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

   arb_state_t     state_q, state_d;
   logic [IDW-1:0] rr_q, rr_d;
   logic [IDW-1:0] lock_q, lock_d;
   logic [IDW-1:0] winner;
   logic [IDW-1:0] sel;
   logic           any_req;
   logic           accept;
   logic           fifo_full;
   logic           fifo_empty;
   logic [IDW-1:0] fifo_head;
   logic [CW-1:0]  fifo_count;
   logic           blocked;
   int             idx;

   // Only the registered occupancy blocks new requests, keeping rvalid off the req path.
   assign blocked = (fifo_count == CW'(MAX_OUTSTANDING));

   // Scanning from the farthest offset down lets the nearest requester at/after rr_q win.
   always_comb begin
      winner  = rr_q;
      any_req = 1'b0;
      idx     = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = int'(rr_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (req_i[IDW'(idx)]) begin
            winner  = IDW'(idx);
            any_req = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      lock_d    = lock_q;
      sel       = winner;
      obi_req_o = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            sel       = winner;
            obi_req_o = any_req & ~blocked;
            if (obi_req_o & ~obi_gnt_i) begin
               lock_d  = winner;
               state_d = ARB_LOCKED;
            end
         end
         ARB_LOCKED: begin
            sel       = lock_q;
            obi_req_o = 1'b1;
            if (obi_gnt_i) state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   assign accept = obi_req_o & obi_gnt_i;

   always_comb begin
      rr_d = rr_q;
      if (accept) begin
         rr_d = (sel == IDW'(NUM_REQ - 1)) ? '0 : sel + IDW'(1);
      end
   end

   always_comb begin
      gnt_o      = '0;
      gnt_o[sel] = accept;
   end

   // Idle manager payload is forced to zero rather than leaking the last winner.
   always_comb begin
      obi_addr_o  = '0;
      obi_we_o    = 1'b0;
      obi_be_o    = '0;
      obi_wdata_o = '0;
      if (obi_req_o) begin
         obi_addr_o  = addr_i[sel];
         obi_we_o    = we_i[sel];
         obi_be_o    = be_i[sel];
         obi_wdata_o = wdata_i[sel];
      end
   end

   assign obi_atop_o = OBI_ATOP_NONE;

   // A response with nothing outstanding is dropped instead of being routed.
   always_comb begin
      rvalid_o = '0;
      if (!fifo_empty) rvalid_o[fifo_head] = obi_rvalid_i;
   end

   assign rdata_o = obi_rdata_i;
   assign err_o   = obi_err_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
         rr_q    <= '0;
         lock_q  <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         lock_q  <= lock_d;
      end
   end

   obi_id_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .W     (IDW),
      .CW    (CW)
   ) u_id_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (accept & ~fifo_full),
      .push_id (sel),
      .pop     (obi_rvalid_i),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .head    (fifo_head),
      .count   (fifo_count)
   );

endmodule

// File: tb/tb_obi_arbiter.sv
// Directed bench for obi_arbiter: a queue-based transaction model checked every cycle,
// plus literal expectations for each scenario.
module tb_obi_arbiter;

   localparam int N    = 2;
   localparam int IW   = 1;
   localparam int W    = 32;
   localparam int MAXO = 2;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [N-1:0]          req_i = '0;
   logic [N-1:0]          gnt_o;
   logic [N-1:0][W-1:0]   addr_i = '0;
   logic [N-1:0]          we_i = '0;
   logic [N-1:0][3:0]     be_i = '0;
   logic [N-1:0][W-1:0]   wdata_i = '0;
   logic [N-1:0]          rvalid_o;
   logic [W-1:0]          rdata_o;
   logic                  err_o;
   logic                  obi_req_o;
   logic                  obi_gnt_i = 1'b0;
   logic [W-1:0]          obi_addr_o;
   logic                  obi_we_o;
   logic [3:0]            obi_be_o;
   logic [W-1:0]          obi_wdata_o;
   logic [5:0]            obi_atop_o;
   logic [W-1:0]          obi_rdata_i = '0;
   logic                  obi_rvalid_i = 1'b0;
   logic                  obi_err_i = 1'b0;

   int checks = 0;
   int failures = 0;

   int outQ[$];
   int rrM = 0;
   int pendM = -1;

   logic          expReq;
   int            expSel;
   logic [N-1:0]  expGnt;
   logic [N-1:0]  expRvalid;
   logic [W-1:0]  expAddr;
   logic [W-1:0]  expWdata;
   logic          expWe;
   logic [3:0]    expBe;

   obi_arbiter #(
      .WIDTH           (W),
      .NUM_REQ         (N),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_i        (req_i),
      .gnt_o        (gnt_o),
      .addr_i       (addr_i),
      .we_i         (we_i),
      .be_i         (be_i),
      .wdata_i      (wdata_i),
      .rvalid_o     (rvalid_o),
      .rdata_o      (rdata_o),
      .err_o        (err_o),
      .obi_req_o    (obi_req_o),
      .obi_gnt_i    (obi_gnt_i),
      .obi_addr_o   (obi_addr_o),
      .obi_we_o     (obi_we_o),
      .obi_be_o     (obi_be_o),
      .obi_wdata_o  (obi_wdata_o),
      .obi_atop_o   (obi_atop_o),
      .obi_rdata_i  (obi_rdata_i),
      .obi_rvalid_i (obi_rvalid_i),
      .obi_err_i    (obi_err_i)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a request that was presented but not granted stays owed to its requester;
   // otherwise the nearest requester at/after the round-robin pointer is served.
   task automatic modelEval();
      logic [IW-1:0] s;
      int c;
      expSel = -1;
      if (pendM >= 0) begin
         expSel = pendM;
      end else if (outQ.size() < MAXO) begin
         for (int k = 0; k < N; k++) begin
            c = (rrM + k) % N;
            if (expSel < 0 && ((req_i >> c) & N'(1)) != '0) expSel = c;
         end
      end
      expReq   = (expSel >= 0);
      expAddr  = '0;
      expWdata = '0;
      expWe    = 1'b0;
      expBe    = '0;
      expGnt   = '0;
      if (expReq) begin
         s        = IW'(expSel);
         expAddr  = addr_i[s];
         expWdata = wdata_i[s];
         expWe    = we_i[s];
         expBe    = be_i[s];
         if (obi_gnt_i) expGnt = N'(1) << expSel;
      end
      expRvalid = '0;
      if (obi_rvalid_i && outQ.size() > 0) expRvalid = N'(1) << outQ[0];
   endtask

   task automatic modelStep();
      modelEval();
      if (obi_rvalid_i && outQ.size() > 0) void'(outQ.pop_front());
      if (expReq && obi_gnt_i) begin
         outQ.push_back(expSel);
         rrM   = (expSel + 1) % N;
         pendM = -1;
      end else if (expReq) begin
         pendM = expSel;
      end
   endtask

   // Model state advances on the same edges as the DUT, reading only bench-driven inputs.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            outQ.delete();
            rrM   = 0;
            pendM = -1;
         end else begin
            modelStep();
         end
      end
   end

   // Every-cycle comparison against the model, sampled mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         modelEval();
         checkOutput("m.obi_req",   32'(obi_req_o),   32'(expReq));
         checkOutput("m.gnt",       32'(gnt_o),       32'(expGnt));
         checkOutput("m.addr",      obi_addr_o,       expAddr);
         checkOutput("m.we",        32'(obi_we_o),    32'(expWe));
         checkOutput("m.be",        32'(obi_be_o),    32'(expBe));
         checkOutput("m.wdata",     obi_wdata_o,      expWdata);
         checkOutput("m.atop",      32'(obi_atop_o),  32'h0);
         checkOutput("m.rvalid",    32'(rvalid_o),    32'(expRvalid));
         checkOutput("m.rdata",     rdata_o,          obi_rdata_i);
         checkOutput("m.err",       32'(err_o),       32'(obi_err_i));
      end
   end

   task automatic setPayload(input int r, input logic [W-1:0] a, input logic we,
                             input logic [3:0] be, input logic [W-1:0] wd);
      addr_i[IW'(r)]  = a;
      we_i[IW'(r)]    = we;
      be_i[IW'(r)]    = be;
      wdata_i[IW'(r)] = wd;
   endtask

   task automatic applyStimulus(input logic [N-1:0] req, input logic gnt, input logic rv,
                                input logic [W-1:0] rd, input logic er);
      req_i        = req;
      obi_gnt_i    = gnt;
      obi_rvalid_i = rv;
      obi_rdata_i  = rd;
      obi_err_i    = er;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      settle();
      checkOutput("rst.obi_req", 32'(obi_req_o), 32'h0);
      checkOutput("rst.gnt",     32'(gnt_o),     32'h0);
      checkOutput("rst.rvalid",  32'(rvalid_o),  32'h0);
      checkOutput("rst.addr",    obi_addr_o,     32'h0);
      advance();
      rst_n = 1'b1;

      // Single read from requester 1
      setPayload(0, 32'h0000_0200, 1'b1, 4'hF, 32'hA0A0_0000);
      setPayload(1, 32'h0000_0100, 1'b0, 4'h3, 32'h0000_1111);
      applyStimulus(2'b10, 1'b1, 1'b0, '0, 1'b0);
      settle();
      checkOutput("read.gnt",  32'(gnt_o),      32'h2);
      checkOutput("read.addr", obi_addr_o,      32'h100);
      checkOutput("read.be",   32'(obi_be_o),   32'h3);
      advance();
      applyStimulus(2'b00, 1'b0, 1'b0, '0, 1'b0);
      advance();
      applyStimulus(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      settle();
      checkOutput("read.rvalid", 32'(rvalid_o), 32'h2);
      checkOutput("read.rdata",  rdata_o,       32'hDEAD_BEEF);
      advance();

      // Fairness with continuous grant and response
      for (int k = 0; k < 5; k++) begin
         applyStimulus(2'b11, 1'b1, 1'b1, 32'hC000_0000 + W'(k), (k == 3));
         settle();
         checkOutput("fair.gnt",    32'(gnt_o),    (k % 2 == 0) ? 32'h1 : 32'h2);
         checkOutput("fair.rvalid", 32'(rvalid_o), (k == 0) ? 32'h0 : ((k % 2 == 1) ? 32'h1 : 32'h2));
         advance();
      end
      applyStimulus(2'b00, 1'b0, 1'b1, 32'h0000_0042, 1'b0);
      settle();
      checkOutput("fair.drain", 32'(rvalid_o), 32'h1);
      advance();

      // Lock: requester 0 waits for grant while requester 1 (next by round-robin) rises
      setPayload(1, 32'h0000_0300, 1'b0, 4'hC, 32'h0000_3333);
      applyStimulus(2'b01, 1'b0, 1'b0, '0, 1'b0);
      settle();
      checkOutput("lock.c1.addr", obi_addr_o,     32'h200);
      checkOutput("lock.c1.req",  32'(obi_req_o), 32'h1);
      advance();
      for (int k = 0; k < 2; k++) begin
         applyStimulus(2'b11, 1'b0, 1'b0, '0, 1'b0);
         settle();
         checkOutput("lock.hold.addr", obi_addr_o, 32'h200);
         checkOutput("lock.hold.gnt",  32'(gnt_o), 32'h0);
         advance();
      end
      applyStimulus(2'b11, 1'b1, 1'b0, '0, 1'b0);
      settle();
      checkOutput("lock.gnt0", 32'(gnt_o), 32'h1);
      advance();
      applyStimulus(2'b10, 1'b1, 1'b0, '0, 1'b0);
      settle();
      checkOutput("lock.gnt1",  32'(gnt_o), 32'h2);
      checkOutput("lock.addr1", obi_addr_o, 32'h300);
      advance();

      // Full stall: two outstanding, requester 0 waits until a response frees a slot
      setPayload(0, 32'h0000_0204, 1'b1, 4'h1, 32'h0000_5A5A);
      applyStimulus(2'b01, 1'b0, 1'b0, '0, 1'b0);
      settle();
      checkOutput("full.req",  32'(obi_req_o), 32'h0);
      checkOutput("full.addr", obi_addr_o,     32'h0);
      advance();
      applyStimulus(2'b01, 1'b0, 1'b1, 32'h0000_5555, 1'b1);
      settle();
      checkOutput("full.rvalid", 32'(rvalid_o),  32'h1);
      checkOutput("full.err",    32'(err_o),     32'h1);
      checkOutput("full.req.pop", 32'(obi_req_o), 32'h0);
      advance();
      applyStimulus(2'b01, 1'b1, 1'b0, '0, 1'b0);
      settle();
      checkOutput("full.req.after", 32'(obi_req_o), 32'h1);
      checkOutput("full.gnt",       32'(gnt_o),     32'h1);
      advance();

      // Simultaneous accept and response with one outstanding
      applyStimulus(2'b00, 1'b0, 1'b1, 32'h0000_0001, 1'b0);
      settle();
      checkOutput("sim.rv1", 32'(rvalid_o), 32'h2);
      advance();
      setPayload(1, 32'h0000_0304, 1'b1, 4'h8, 32'h0000_7777);
      applyStimulus(2'b10, 1'b1, 1'b1, 32'h0000_0002, 1'b0);
      settle();
      checkOutput("sim.gnt", 32'(gnt_o),    32'h2);
      checkOutput("sim.rv2", 32'(rvalid_o), 32'h1);
      advance();
      applyStimulus(2'b00, 1'b0, 1'b1, 32'h0000_0003, 1'b0);
      settle();
      checkOutput("sim.rv3", 32'(rvalid_o), 32'h2);
      advance();
      applyStimulus(2'b00, 1'b0, 1'b1, 32'h0000_0004, 1'b0);
      settle();
      checkOutput("stray.rvalid", 32'(rvalid_o), 32'h0);
      advance();

      // Reset with two outstanding and the round-robin pointer at 1
      for (int k = 0; k < 2; k++) begin
         applyStimulus(2'b01, 1'b1, 1'b0, '0, 1'b0);
         settle();
         checkOutput("pre.gnt", 32'(gnt_o), 32'h1);
         advance();
      end
      applyStimulus(2'b00, 1'b0, 1'b0, '0, 1'b0);
      rst_n = 1'b0;
      settle();
      checkOutput("midrst.req", 32'(obi_req_o), 32'h0);
      checkOutput("midrst.gnt", 32'(gnt_o),     32'h0);
      advance();
      rst_n = 1'b1;
      applyStimulus(2'b00, 1'b0, 1'b1, 32'h0000_00AA, 1'b0);
      settle();
      checkOutput("postrst.late", 32'(rvalid_o), 32'h0);
      advance();
      applyStimulus(2'b11, 1'b1, 1'b0, '0, 1'b0);
      settle();
      checkOutput("postrst.gnt", 32'(gnt_o), 32'h1);
      advance();
      applyStimulus(2'b00, 1'b0, 1'b1, 32'h0000_00BB, 1'b0);
      settle();
      checkOutput("postrst.rv", 32'(rvalid_o), 32'h1);
      advance();
      applyStimulus(2'b00, 1'b0, 1'b1, 32'h0000_00CC, 1'b0);
      settle();
      checkOutput("postrst.empty", 32'(rvalid_o), 32'h0);
      advance();
      applyStimulus(2'b00, 1'b0, 1'b0, '0, 1'b0);
      advance();
      settle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
